// File: rtl/qpp_pkg.sv
// Shared constants, FSM state type and modular-add helper for the QPP
// interleaver/deinterleaver pair.
package qpp_pkg;

  localparam int DATA_W = 8;
  localparam int W      = 16;
  localparam int MAX_N  = 6144;
  localparam int AW     = $clog2(MAX_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  // Both operands are already reduced below n, so a single subtract suffices.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] n);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, n}) begin
      sum = sum - {1'b0, n};
    end
    return sum[W-1:0];
  endfunction

endpackage

// File: rtl/qpp_deinterleaver_if.sv
// Configuration, input-stream and output-stream bundle for the deinterleaver.
// The master side drives config and input symbols; the slave is the block.
interface qpp_deinterleaver_if;
  import qpp_pkg::*;

  logic              start;
  logic [W-1:0]      N;
  logic [W-1:0]      f1;
  logic [W-1:0]      f2;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;
  logic              busy;
  logic              cfg_err;

  modport master (
    output start, N, f1, f2, s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, busy, cfg_err
  );

  modport slave (
    input  start, N, f1, f2, s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, busy, cfg_err
  );

endinterface

// File: rtl/qpp_addr_gen.sv
// Incremental QPP address generator: pi(i+1) = pi(i) + gamma(i), with gamma
// stepping by 2*f2, all mod n. Shared with the transmit-side interleaver.
module qpp_addr_gen
  import qpp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          advance,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  f1,
  input  logic [W-1:0]  f2,
  output logic [AW-1:0] pi
);

  logic [W-1:0] pi_q;
  logic [W-1:0] gamma_q;
  logic [W-1:0] g_q;

  // gamma(0) = f1 + f2 and g = 2*f2 are the first and second differences of pi.
  always_ff @(posedge clk) begin
    if (rst) begin
      pi_q    <= '0;
      gamma_q <= '0;
      g_q     <= '0;
    end else if (init) begin
      pi_q    <= '0;
      gamma_q <= mod_add(f1, f2, n);
      g_q     <= mod_add(f2, f2, n);
    end else if (advance) begin
      pi_q    <= mod_add(pi_q, gamma_q, n);
      gamma_q <= mod_add(gamma_q, g_q, n);
    end
  end

  assign pi = pi_q[AW-1:0];

endmodule

// File: rtl/qpp_deinterleaver.sv
// QPP deinterleaver: writes symbol i to buffer address pi(i), then streams the
// buffer out in natural order through a two-entry skid stage.
module qpp_deinterleaver
  import qpp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  qpp_deinterleaver_if.slave bus
);

  state_t state;
  state_t state_nxt;

  logic [W-1:0]      n_q;
  logic [W-1:0]      f1_q;
  logic [W-1:0]      f2_q;
  logic [W-1:0]      wcnt;
  logic [AW-1:0]     pi;
  logic [AW-1:0]     raddr;
  logic [AW-1:0]     last_addr;
  logic [AW-1:0]     ram_addr;

  logic              cfg_bad;
  logic              s_ready;
  logic              busy;
  logic              init_pi;
  logic              accept;
  logic              last_write;
  logic              issue;
  logic              pop;
  logic              last_pop;
  logic [1:0]        occ;

  logic              cfg_err_q;
  logic              rd_active;
  logic              pend;
  logic              pend_last;
  logic              sk_valid;
  logic              sk_last;
  logic [DATA_W-1:0] sk_data;
  logic              m_valid_q;
  logic              m_last_q;
  logic [DATA_W-1:0] m_data_q;
  logic [DATA_W-1:0] rdata;

  logic [DATA_W-1:0] mem [0:MAX_N-1];

  assign cfg_bad = (bus.N == '0) || (bus.N > W'(MAX_N)) ||
                   (bus.f1 >= bus.N) || (bus.f2 >= bus.N);

  assign accept     = s_ready & bus.s_valid;
  assign last_write = (wcnt == n_q - 1'b1);
  assign last_addr  = AW'(n_q - 1'b1);
  assign pop        = m_valid_q & bus.m_ready;
  assign last_pop   = pop & m_last_q;

  // Every read in flight needs a guaranteed landing slot (output or skid).
  assign occ   = 2'(m_valid_q) + 2'(sk_valid) + 2'(pend);
  assign issue = (state == READ) && rd_active && ((occ - 2'(pop)) < 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b1;
    init_pi   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start && !cfg_bad) begin
          state_nxt = INIT;
        end
      end
      INIT: begin
        init_pi   = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        s_ready = 1'b1;
        if (bus.s_valid && last_write) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (last_pop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  qpp_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .init    (init_pi),
    .advance (accept),
    .n       (n_q),
    .f1      (f1_q),
    .f2      (f2_q),
    .pi      (pi)
  );

  // Write and read phases never overlap, so one port serves both.
  assign ram_addr = (state == READ) ? raddr : pi;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ram_addr] <= bus.s_data;
    end
    rdata <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      f1_q      <= '0;
      f2_q      <= '0;
      cfg_err_q <= 1'b0;
      wcnt      <= '0;
      raddr     <= '0;
      rd_active <= 1'b0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      sk_valid  <= 1'b0;
      sk_last   <= 1'b0;
      sk_data   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      cfg_err_q <= (state == IDLE) && bus.start && cfg_bad;

      if ((state == IDLE) && bus.start && !cfg_bad) begin
        n_q  <= bus.N;
        f1_q <= bus.f1;
        f2_q <= bus.f2;
      end

      if (state == INIT) begin
        wcnt <= '0;
      end else if (accept) begin
        wcnt <= wcnt + 1'b1;
      end

      if (accept && last_write) begin
        raddr     <= '0;
        rd_active <= 1'b1;
      end else if (issue) begin
        raddr <= raddr + 1'b1;
        if (raddr == last_addr) begin
          rd_active <= 1'b0;
        end
      end

      pend      <= issue;
      pend_last <= issue && (raddr == last_addr);

      // Skid data is older than RAM data, so it always drains first.
      if (!m_valid_q || pop) begin
        if (sk_valid) begin
          m_valid_q <= 1'b1;
          m_data_q  <= sk_data;
          m_last_q  <= sk_last;
          sk_valid  <= pend;
          if (pend) begin
            sk_data <= rdata;
            sk_last <= pend_last;
          end
        end else if (pend) begin
          m_valid_q <= 1'b1;
          m_data_q  <= rdata;
          m_last_q  <= pend_last;
        end else begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      end else if (pend) begin
        sk_valid <= 1'b1;
        sk_data  <= rdata;
        sk_last  <= pend_last;
      end
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.busy    = busy;
  assign bus.cfg_err = cfg_err_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Self-checking bench for qpp_deinterleaver: directed tables plus hand-written
// block sequences checked against a closed-form QPP model.
module tb_qpp_deinterleaver;
  import qpp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qpp_deinterleaver_if bus ();

  qpp_deinterleaver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] nat [0:MAX_N-1];
  logic [DATA_W-1:0] got [0:MAX_N-1];

  typedef struct {
    int n;
    int f1;
    int f2;
  } cfg_vec_t;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] exp;
  } spot_vec_t;

  cfg_vec_t  cfg_vecs  [4];
  spot_vec_t spot_vecs [6];

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Direct evaluation of the permutation, independent of any recurrence.
  function automatic int golden_pi(input int i, input int n, input int f1, input int f2);
    longint v;
    v = (longint'(f1) * i + longint'(f2) * i * i) % n;
    return int'(v);
  endfunction

  task automatic apply_stimulus(input int n, input int f1, input int f2);
    bus.start = 1'b1;
    bus.N     = 16'(n);
    bus.f1    = 16'(f1);
    bus.f2    = 16'(f2);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic write_phase(input int n, input int f1, input int f2,
                             input int count, input int s_pct);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    while (i < count && cyc < count * 20 + 50) begin
      bus.s_valid = ($urandom_range(99) < s_pct);
      bus.s_data  = nat[golden_pi(i, n, f1, f2)];
      if (bus.s_valid && bus.s_ready) i++;
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    check_output("write_count", i, count);
  endtask

  task automatic read_phase(input int n, input int m_pct);
    int k, cyc, bad, last_bad, hold_bad;
    logic prev_stall;
    logic prev_last;
    logic [DATA_W-1:0] prev_data;
    k = 0; cyc = 0; bad = 0; last_bad = 0; hold_bad = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    while (k < n && cyc < n * 20 + 50) begin
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        hold_bad++;
      bus.m_ready = ($urandom_range(99) < m_pct);
      if (bus.m_valid && bus.m_ready) begin
        got[k] = bus.m_data;
        if (bus.m_data !== nat[k]) bad++;
        if (bus.m_last !== (k == n - 1)) last_bad++;
        k++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      @(negedge clk);
      cyc++;
    end
    bus.m_ready = 1'b0;
    check_output("read_count", k, n);
    check_output("order_errs", bad, 0);
    check_output("last_errs", last_bad, 0);
    check_output("stall_hold_errs", hold_bad, 0);
    check_output("busy_after_block", bus.busy, 1'b0);
    check_output("m_valid_after_block", bus.m_valid, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_s_ready", bus.s_ready, 1'b0);
    check_output("rst_m_valid", bus.m_valid, 1'b0);
    check_output("rst_m_last", bus.m_last, 1'b0);
    check_output("rst_m_data", bus.m_data, '0);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_cfg_err", bus.cfg_err, 1'b0);
  endtask

  initial begin
    cfg_vecs[0] = '{0, 0, 0};
    cfg_vecs[1] = '{6145, 1, 1};
    cfg_vecs[2] = '{40, 3, 40};
    cfg_vecs[3] = '{40, 40, 3};

    // N=40, f1=3, f2=10 with s_data=i: out[pi(i)] = i.
    spot_vecs[0] = '{0, 8'd0};
    spot_vecs[1] = '{13, 8'd1};
    spot_vecs[2] = '{6, 8'd2};
    spot_vecs[3] = '{19, 8'd3};
    spot_vecs[4] = '{12, 8'd4};
    spot_vecs[5] = '{25, 8'd5};

    rst = 1'b1;
    bus.start = 1'b0; bus.N = '0; bus.f1 = '0; bus.f2 = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    bus.s_valid = 1'b1;
    @(negedge clk);
    check_output("idle_s_ready", bus.s_ready, 1'b0);
    bus.s_valid = 1'b0;

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(cfg_vecs[v].n, cfg_vecs[v].f1, cfg_vecs[v].f2);
      check_output($sformatf("cfg_err_pulse[%0d]", v), bus.cfg_err, 1'b1);
      check_output($sformatf("cfg_busy[%0d]", v), bus.busy, 1'b0);
      @(negedge clk);
      check_output($sformatf("cfg_err_clear[%0d]", v), bus.cfg_err, 1'b0);
    end

    for (int i = 0; i < 40; i++) nat[golden_pi(i, 40, 3, 10)] = 8'(i);
    apply_stimulus(40, 3, 10);
    write_phase(40, 3, 10, 40, 100);
    read_phase(40, 100);
    for (int v = 0; v < 6; v++)
      check_output($sformatf("spot_out[%0d]", spot_vecs[v].idx), got[spot_vecs[v].idx], spot_vecs[v].exp);

    // N=1 block with a second start while busy that must be ignored.
    nat[0] = 8'hA5;
    apply_stimulus(1, 0, 0);
    bus.start = 1'b1;
    bus.N     = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check_output("busy_start_no_err", bus.cfg_err, 1'b0);
    check_output("busy_during_block", bus.busy, 1'b1);
    write_phase(1, 0, 0, 1, 100);
    read_phase(1, 100);
    check_output("n1_data", got[0], 8'hA5);

    for (int k = 0; k < MAX_N; k++) nat[k] = 8'(k ^ (k >> 5));
    apply_stimulus(6144, 263, 480);
    write_phase(6144, 263, 480, 6144, 100);
    read_phase(6144, 100);

    for (int k = 0; k < 40; k++) nat[k] = 8'($urandom_range(255));
    apply_stimulus(40, 3, 10);
    write_phase(40, 3, 10, 40, 50);
    read_phase(40, 50);

    apply_stimulus(40, 3, 10);
    write_phase(40, 3, 10, 17, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    for (int k = 0; k < 40; k++) nat[k] = 8'($urandom_range(255));
    apply_stimulus(40, 3, 10);
    write_phase(40, 3, 10, 40, 100);
    read_phase(40, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
